// File: rtl/mips_iter_shift_unit.sv
// Multi-cycle shift unit for the MIPS datapath: SLL, SRL, SRA and ROTR,
// shifting at most STEP bits per clock with a start/done/kill handshake.
module mips_iter_shift_unit #(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] operand,
    input  logic [SW-1:0]    shamt,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // state | meaning
    // IDLE  | waiting for start, ready=1
    // SHIFT | stepping the working register, busy=1
    // DONE  | result just updated, done=1, start accepted back-to-back
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // One extra bit so STEP=WIDTH is representable.
    localparam logic [SW:0] STEP_C  = (SW+1)'(STEP);
    localparam logic [SW:0] WIDTH_C = (SW+1)'(WIDTH);

    state_t             state, state_next;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   shift_val;
    logic [SW-1:0]      remaining;
    logic [1:0]         mode_q;
    logic [SW:0]        s_wide;
    logic [SW:0]        rot_l;
    logic               accept;
    logic               last_step;

    // Per-cycle step distance s = min(STEP, remaining); never zero in SHIFT.
    always_comb begin
        s_wide    = ({1'b0, remaining} < STEP_C) ? {1'b0, remaining} : STEP_C;
        rot_l     = WIDTH_C - s_wide;
        last_step = ({1'b0, remaining} == s_wide);
    end

    // One step of the latched mode applied to the working register.
    // SRA keeps the latched sign in the MSB, so >>> on work replicates it.
    always_comb begin
        shift_val = work;
        case (mode_q)
            2'b00:   shift_val = work << s_wide;
            2'b01:   shift_val = work >> s_wide;
            2'b10:   shift_val = WIDTH'($signed(work) >>> s_wide);
            default: shift_val = (work >> s_wide) | (work << rot_l);
        endcase
    end

    // Next-state decode; kill overrides everything including a start.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        if (kill) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        accept     = 1'b1;
                        state_next = (shamt == '0) ? DONE : SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
                SHIFT:   if (last_step) state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Working register, remaining count, latched mode and held result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            work      <= '0;
            remaining <= '0;
            mode_q    <= '0;
            result    <= '0;
        end else if (kill) begin
            work      <= '0;
            remaining <= '0;
        end else if (accept) begin
            work      <= operand;
            remaining <= shamt;
            mode_q    <= mode;
            if (shamt == '0) result <= operand;
        end else if (state == SHIFT) begin
            work      <= shift_val;
            remaining <= remaining - s_wide[SW-1:0];
            if (last_step) result <= shift_val;
        end
    end

    // Handshake outputs decoded straight from state.
    always_comb begin
        ready = (state != SHIFT);
        busy  = (state == SHIFT);
        done  = (state == DONE);
    end

endmodule
